// File: rtl/uart_apb_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : uart_apb_ctrl
// Description : APB3 slave front-end for the UART: TX push / RX pop, status,
//               baud divisor and interrupt control registers. The optional
//               interrupt logic and CTRL register are built when UART_APB_IRQ_EN
//               is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_apb_ctrl #(
    parameter logic [10:0] BAUD_RESET = 11'd325
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [3:0]  PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    output logic [10:0] baud_final_value,
    output logic [7:0]  tx_fifo_dataIn,
    output logic        tx_fifo_writeEn,
    input  logic        tx_fifo_Full,
    output logic        rx_fifo_readEn,
    input  logic        rx_fifo_Empty,
    input  logic [7:0]  rx_fifo_dataOut,
    output logic        irq
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ACCESS  = 3'd1,
        RD_POP  = 3'd2,
        RD_CAP  = 3'd3,
        RD_DONE = 3'd4
    } state_t;

    localparam logic [1:0] OFF_DATA   = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_BAUD   = 2'd2;

    state_t      state_q, state_d;
    logic [10:0] baud_q, baud_d;
    logic        tx_drop_q, tx_drop_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_we_q, tx_we_d;
    logic [7:0]  rx_byte_q, rx_byte_d;
`ifdef UART_APB_IRQ_EN
    logic [1:0]  ctrl_q, ctrl_d;
    logic        irq_q, irq_d;
`endif

    logic [1:0]  offset;
    logic        unused_bits;

    assign offset      = PADDR[3:2];
    assign unused_bits = ^{PADDR[1:0], PWDATA[31:11]};

    always_comb begin
        state_d        = state_q;
        baud_d         = baud_q;
        tx_drop_d      = tx_drop_q;
        tx_data_d      = tx_data_q;
        tx_we_d        = 1'b0;
        rx_byte_d      = rx_byte_q;
`ifdef UART_APB_IRQ_EN
        ctrl_d         = ctrl_q;
`endif
        PREADY         = 1'b0;
        PSLVERR        = 1'b0;
        PRDATA         = 32'h0;
        rx_fifo_readEn = 1'b0;

        case (state_q)
            IDLE: begin
                if (PSEL) begin
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (!PSEL) begin
                    state_d = IDLE;
                end else if (PENABLE) begin
                    // Only a DATA read with bytes waiting needs the pop/capture detour.
                    if (!PWRITE && offset == OFF_DATA && !rx_fifo_Empty) begin
                        state_d = RD_POP;
                    end else begin
                        PREADY  = 1'b1;
                        state_d = IDLE;
                        case (offset)
                            OFF_DATA: begin
                                if (PWRITE) begin
                                    if (tx_fifo_Full) begin
                                        PSLVERR   = 1'b1;
                                        tx_drop_d = 1'b1;
                                    end else begin
                                        tx_we_d   = 1'b1;
                                        tx_data_d = PWDATA[7:0];
                                    end
                                end else begin
                                    PSLVERR = 1'b1;
                                end
                            end
                            OFF_STATUS: begin
                                if (PWRITE) begin
                                    if (PWDATA[2]) begin
                                        tx_drop_d = 1'b0;
                                    end
                                end else begin
                                    PRDATA = {29'h0, tx_drop_q, rx_fifo_Empty, tx_fifo_Full};
                                end
                            end
                            OFF_BAUD: begin
                                if (PWRITE) begin
                                    baud_d = PWDATA[10:0];
                                end else begin
                                    PRDATA = {21'h0, baud_q};
                                end
                            end
                            default: begin
`ifdef UART_APB_IRQ_EN
                                if (PWRITE) begin
                                    ctrl_d = PWDATA[1:0];
                                end else begin
                                    PRDATA = {30'h0, ctrl_q};
                                end
`endif
                            end
                        endcase
                    end
                end
            end
            RD_POP: begin
                rx_fifo_readEn = 1'b1;
                state_d        = PSEL ? RD_CAP : IDLE;
            end
            RD_CAP: begin
                rx_byte_d = rx_fifo_dataOut;
                state_d   = PSEL ? RD_DONE : IDLE;
            end
            RD_DONE: begin
                state_d = IDLE;
                if (PSEL) begin
                    PREADY = 1'b1;
                    PRDATA = {24'h0, rx_byte_q};
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            baud_q    <= BAUD_RESET;
            tx_drop_q <= 1'b0;
            tx_data_q <= 8'h0;
            tx_we_q   <= 1'b0;
            rx_byte_q <= 8'h0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            tx_drop_q <= tx_drop_d;
            tx_data_q <= tx_data_d;
            tx_we_q   <= tx_we_d;
            rx_byte_q <= rx_byte_d;
        end
    end

`ifdef UART_APB_IRQ_EN
    always_comb begin
        irq_d = (ctrl_q[0] & ~rx_fifo_Empty) | (ctrl_q[1] & ~tx_fifo_Full) | tx_drop_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q <= 2'b00;
            irq_q  <= 1'b0;
        end else begin
            ctrl_q <= ctrl_d;
            irq_q  <= irq_d;
        end
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

    assign baud_final_value = baud_q;
    assign tx_fifo_dataIn   = tx_data_q;
    assign tx_fifo_writeEn  = tx_we_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_apb_ctrl.sv
`default_nettype none
// Testbench for uart_apb_ctrl: directed register vectors, randomized transfers
// against a register/FIFO model, and hand sequences for aborts and reset.
module tb_uart_apb_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        PSEL, PENABLE, PWRITE;
    logic [3:0]  PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY, PSLVERR;
    logic [10:0] baud_final_value;
    logic [7:0]  tx_fifo_dataIn;
    logic        tx_fifo_writeEn;
    logic        tx_fifo_Full;
    logic        rx_fifo_readEn;
    logic        rx_fifo_Empty;
    logic [7:0]  rx_fifo_dataOut;
    logic        irq;

    always #5 clk = ~clk;

    uart_apb_ctrl dut (
        .clk(clk), .reset(reset),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .baud_final_value(baud_final_value),
        .tx_fifo_dataIn(tx_fifo_dataIn), .tx_fifo_writeEn(tx_fifo_writeEn), .tx_fifo_Full(tx_fifo_Full),
        .rx_fifo_readEn(rx_fifo_readEn), .rx_fifo_Empty(rx_fifo_Empty), .rx_fifo_dataOut(rx_fifo_dataOut),
        .irq(irq)
    );

    int passed = 0;
    int total  = 0;

    // Cycle counter and TX strobe monitor, sampled on the falling edge.
    int cyc = 0;
    int tx_cnt = 0;
    int tx_last_cyc = 0;
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (tx_fifo_writeEn) begin
            tx_cnt      <= tx_cnt + 1;
            tx_last_cyc <= cyc + 1;
        end
    end

    // Reference model state
    logic [7:0]  rxq[$];
    logic [10:0] m_baud;
    logic        m_drop;
`ifdef UART_APB_IRQ_EN
    logic [1:0]  m_ctrl;
`endif

    typedef struct {
        logic        w;
        logic [3:0]  a;
        logic [31:0] d;
        logic        full;
        logic        rx_v;
        logic [7:0]  rx_b;
        logic [31:0] e_rd;
        logic        e_err;
        int          e_lat;
        logic        e_push;
        logic [7:0]  e_byte;
    } vec_t;
    vec_t vt[14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    task automatic rx_push(input logic [7:0] b);
        rxq.push_back(b);
        rx_fifo_Empty = 1'b0;
    endtask

    function automatic logic model_irq();
`ifdef UART_APB_IRQ_EN
        return (m_ctrl[0] & (rxq.size() != 0)) | (m_ctrl[1] & ~tx_fifo_Full) | m_drop;
`else
        return 1'b0;
`endif
    endfunction

    // Register-map behaviour; a successful pop costs ACCESS plus the two
    // inserted wait states before PREADY, i.e. three low-PREADY access cycles.
    task automatic model_predict(input logic w, input logic [3:0] a, input logic [31:0] d,
                                 output logic [31:0] e_rd, output logic e_err, output int e_lat,
                                 output logic e_push, output logic [7:0] e_byte);
        e_rd = 32'h0; e_err = 1'b0; e_lat = 0; e_push = 1'b0; e_byte = 8'h0;
        case (a[3:2])
            2'd0: begin
                if (w) begin
                    if (tx_fifo_Full) begin e_err = 1'b1; m_drop = 1'b1; end
                    else begin e_push = 1'b1; e_byte = d[7:0]; end
                end else if (rxq.size() == 0) begin
                    e_err = 1'b1;
                end else begin
                    e_rd = {24'h0, rxq[0]}; e_lat = 3;
                end
            end
            2'd1: begin
                if (w) begin
                    if (d[2]) m_drop = 1'b0;
                end else begin
                    e_rd = {29'h0, m_drop, (rxq.size() == 0) ? 1'b1 : 1'b0, tx_fifo_Full};
                end
            end
            2'd2: begin
                if (w) m_baud = d[10:0];
                else e_rd = {21'h0, m_baud};
            end
            default: begin
`ifdef UART_APB_IRQ_EN
                if (w) m_ctrl = d[1:0];
                else e_rd = {30'h0, m_ctrl};
`endif
            end
        endcase
    endtask

    // One APB transfer; also acts as the RX FIFO, returning the popped byte
    // one cycle after rx_fifo_readEn (garbage during the pop cycle itself).
    task automatic apb_xfer(input logic w, input logic [3:0] a, input logic [31:0] d,
                            output logic [31:0] rd, output logic err, output int lat,
                            output int rc, output bit ok, output bit nz);
        logic [7:0] pv;
        bit pend;
        rd = 32'h0; err = 1'b0; lat = 0; rc = 0; ok = 1'b0; nz = 1'b0; pend = 1'b0; pv = 8'h0;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = w; PADDR = a; PWDATA = d;
        @(negedge clk); PENABLE = 1'b1; #1;
        for (int i = 0; i < 12; i++) begin
            if (pend) begin rx_fifo_dataOut = pv; pend = 1'b0; end
            if (rx_fifo_readEn && rxq.size() > 0) begin
                pv = rxq.pop_front();
                rx_fifo_Empty = (rxq.size() == 0);
                rx_fifo_dataOut = 8'hEE;
                pend = 1'b1;
            end
            if (PREADY) begin rd = PRDATA; err = PSLVERR; rc = cyc; ok = 1'b1; break; end
            if (PRDATA != 32'h0) nz = 1'b1;
            lat++;
            @(negedge clk); #1;
        end
        @(negedge clk); PSEL = 1'b0; PENABLE = 1'b0; #1;
    endtask

    task automatic run_xfer(input logic w, input logic [3:0] a, input logic [31:0] d,
                            input logic [31:0] e_rd, input logic e_err, input int e_lat,
                            input logic e_push, input logic [7:0] e_byte, input bit do_irq);
        logic [31:0] rd; logic err; int lat, rc, tx0; bit ok, nz;
        tx0 = tx_cnt;
        apb_xfer(w, a, d, rd, err, lat, rc, ok, nz);
        chk("xfer_done", ok, 1);
        if (!w) chk("prdata", rd, e_rd);
        chk("pslverr", err, e_err);
        chk("access_cycles_before_ready", lat, e_lat);
        chk("prdata_zero_while_waiting", nz, 0);
        chk("tx_push_count", tx_cnt - tx0, e_push);
        if (e_push) begin
            chk("tx_push_cycle", tx_last_cyc, rc + 1);
            chk("tx_data", tx_fifo_dataIn, e_byte);
        end
        chk("baud_out", baud_final_value, m_baud);
        if (do_irq) begin
            @(negedge clk); #1;
            chk("irq", irq, model_irq());
        end
    endtask

    task automatic model_xfer(input logic w, input logic [3:0] a, input logic [31:0] d, input bit do_irq);
        logic [31:0] e_rd; logic e_err, e_push; int e_lat; logic [7:0] e_byte;
        model_predict(w, a, d, e_rd, e_err, e_lat, e_push, e_byte);
        run_xfer(w, a, d, e_rd, e_err, e_lat, e_push, e_byte, do_irq);
    endtask

    initial begin
        logic [31:0] x_rd; logic x_err, x_push; int x_lat; logic [7:0] x_byte;
        int tx0;
        logic e_irq_on;

        //          w     a     d         full  rx_v  rx_b   e_rd        e_err e_lat e_push e_byte
        vt[0]  = '{1'b0, 4'h8, 32'h0,     1'b0, 1'b0, 8'h00, 32'h145,   1'b0, 0, 1'b0, 8'h00};
        vt[1]  = '{1'b1, 4'h8, 32'h1B2,   1'b0, 1'b0, 8'h00, 32'h0,     1'b0, 0, 1'b0, 8'h00};
        vt[2]  = '{1'b0, 4'h8, 32'h0,     1'b0, 1'b0, 8'h00, 32'h1B2,   1'b0, 0, 1'b0, 8'h00};
        vt[3]  = '{1'b1, 4'h0, 32'hA5,    1'b0, 1'b0, 8'h00, 32'h0,     1'b0, 0, 1'b1, 8'hA5};
        vt[4]  = '{1'b1, 4'h0, 32'h5A,    1'b1, 1'b0, 8'h00, 32'h0,     1'b1, 0, 1'b0, 8'h00};
        vt[5]  = '{1'b0, 4'h4, 32'h0,     1'b1, 1'b1, 8'h3C, 32'h5,     1'b0, 0, 1'b0, 8'h00};
        vt[6]  = '{1'b1, 4'h4, 32'h4,     1'b1, 1'b0, 8'h00, 32'h0,     1'b0, 0, 1'b0, 8'h00};
        vt[7]  = '{1'b0, 4'h4, 32'h0,     1'b1, 1'b0, 8'h00, 32'h1,     1'b0, 0, 1'b0, 8'h00};
        vt[8]  = '{1'b0, 4'h0, 32'h0,     1'b1, 1'b0, 8'h00, 32'h3C,    1'b0, 3, 1'b0, 8'h00};
        vt[9]  = '{1'b0, 4'h0, 32'h0,     1'b1, 1'b0, 8'h00, 32'h0,     1'b1, 0, 1'b0, 8'h00};
        vt[10] = '{1'b0, 4'h4, 32'h0,     1'b0, 1'b0, 8'h00, 32'h2,     1'b0, 0, 1'b0, 8'h00};
        vt[11] = '{1'b1, 4'h4, 32'h3,     1'b0, 1'b0, 8'h00, 32'h0,     1'b0, 0, 1'b0, 8'h00};
        vt[12] = '{1'b0, 4'h7, 32'h0,     1'b0, 1'b0, 8'h00, 32'h2,     1'b0, 0, 1'b0, 8'h00};
        vt[13] = '{1'b0, 4'hC, 32'h0,     1'b0, 1'b0, 8'h00, 32'h0,     1'b0, 0, 1'b0, 8'h00};

        reset = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 4'h0; PWDATA = 32'h0;
        tx_fifo_Full = 1'b0; rx_fifo_Empty = 1'b1; rx_fifo_dataOut = 8'h0;
        m_baud = 11'd325; m_drop = 1'b0;
`ifdef UART_APB_IRQ_EN
        m_ctrl = 2'b00;
        e_irq_on = 1'b1;
`else
        e_irq_on = 1'b0;
`endif

        repeat (2) @(negedge clk);
        #1;
        chk("rst_pready", PREADY, 0);
        chk("rst_prdata", PRDATA, 0);
        chk("rst_pslverr", PSLVERR, 0);
        chk("rst_tx_we", tx_fifo_writeEn, 0);
        chk("rst_rx_re", rx_fifo_readEn, 0);
        chk("rst_tx_data", tx_fifo_dataIn, 0);
        chk("rst_baud", baud_final_value, 11'd325);
        chk("rst_irq", irq, 0);
        @(negedge clk); reset = 1'b0; #1;

        // Directed register-map vectors
        for (int i = 0; i < 14; i++) begin
            tx_fifo_Full = vt[i].full;
            if (vt[i].rx_v) rx_push(vt[i].rx_b);
            model_predict(vt[i].w, vt[i].a, vt[i].d, x_rd, x_err, x_lat, x_push, x_byte);
            run_xfer(vt[i].w, vt[i].a, vt[i].d, vt[i].e_rd, vt[i].e_err, vt[i].e_lat,
                     vt[i].e_push, vt[i].e_byte, 1'b1);
        end

        // Randomized transfers, back-to-back when no irq check is requested
        for (int n = 0; n < 200; n++) begin
            logic w; logic [3:0] a; logic [31:0] d;
            tx_fifo_Full = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 2) == 0 && rxq.size() < 4) rx_push(8'($urandom_range(0, 255)));
            w = 1'($urandom_range(0, 1));
            a = 4'($urandom_range(0, 15));
            d = $urandom();
            model_xfer(w, a, d, ($urandom_range(0, 1) == 1));
        end

        // PSEL dropped before the access phase of a DATA write: no strobe
        tx_fifo_Full = 1'b0;
        tx0 = tx_cnt;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 4'h0; PWDATA = 32'h99;
        @(negedge clk); PSEL = 1'b0; #1;
        chk("abort_wr_pready", PREADY, 0);
        repeat (2) @(negedge clk);
        #1;
        chk("abort_wr_no_push", tx_cnt - tx0, 0);

        // PSEL dropped during RD_POP: the pop stands, the transfer is abandoned
        rx_push(8'h77);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 4'h0;
        @(negedge clk); PENABLE = 1'b1; #1;
        @(negedge clk); #1;
        chk("abort_rd_pop_strobe", rx_fifo_readEn, 1);
        if (rx_fifo_readEn && rxq.size() > 0) void'(rxq.pop_front());
        rx_fifo_Empty = (rxq.size() == 0);
        PSEL = 1'b0; PENABLE = 1'b0;
        @(negedge clk); #1;
        chk("abort_rd_pready", PREADY, 0);
        chk("abort_rd_no_second_pop", rx_fifo_readEn, 0);
        model_xfer(1'b0, 4'h4, 32'h0, 1'b1);

        // Reset asserted while in RD_CAP
        rx_push(8'h5E);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 4'h0;
        @(negedge clk); PENABLE = 1'b1; #1;
        @(negedge clk); #1;
        if (rx_fifo_readEn && rxq.size() > 0) void'(rxq.pop_front());
        rx_fifo_Empty = (rxq.size() == 0);
        @(negedge clk); #1;
        chk("rdcap_pready", PREADY, 0);
        reset = 1'b1; #1;
        chk("midrst_pready", PREADY, 0);
        chk("midrst_prdata", PRDATA, 0);
        chk("midrst_rx_re", rx_fifo_readEn, 0);
        chk("midrst_tx_data", tx_fifo_dataIn, 0);
        chk("midrst_baud", baud_final_value, 11'd325);
        chk("midrst_irq", irq, 0);
        PSEL = 1'b0; PENABLE = 1'b0;
        m_baud = 11'd325; m_drop = 1'b0;
`ifdef UART_APB_IRQ_EN
        m_ctrl = 2'b00;
`endif
        @(negedge clk); reset = 1'b0; #1;
        model_xfer(1'b0, 4'h4, 32'h0, 1'b1);

        // RX interrupt: drain, enable rx_irq_en, then make the RX FIFO non-empty
        while (rxq.size() > 0) model_xfer(1'b0, 4'h0, 32'h0, 1'b0);
        tx_fifo_Full = 1'b1;
        model_xfer(1'b1, 4'hC, 32'h1, 1'b1);
        model_xfer(1'b0, 4'hC, 32'h0, 1'b1);
        rx_push(8'h42); #1;
        chk("irq_not_combinational", irq, 0);
        @(negedge clk); #1;
        chk("irq_after_rx_nonempty", irq, e_irq_on);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
